// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard frame receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;
   localparam logic [7:0] CODE_NUL = 8'h00;
   localparam logic [7:0] CODE_ERR = 8'hFF;

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } fifo_entry_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one PS/2 line.
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync_reg;
   logic [CW-1:0] cnt_reg;
   logic          filt_reg;

   // Count consecutive samples that disagree with the filtered level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= 2'b11;
         cnt_reg  <= '0;
         filt_reg <= 1'b1;
      end else begin
         sync_reg <= {sync_reg[0], din};
         if (sync_reg[1] == filt_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
            filt_reg <= sync_reg[1];
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign dout = filt_reg;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver with prefix decoding, keycode history and FWFT FIFO.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_DEPTH  = 8,
   parameter int HIST_BYTES  = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               kclk,
   input  logic                               kdata,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic [7:0]                         m_code,
   output logic                               m_brk,
   output logic                               m_ext,
   output logic [8*HIST_BYTES-1:0]            hist,
   output logic                               err_parity,
   output logic                               err_frame,
   output logic                               overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int HW = 8 * HIST_BYTES;

   logic [1:0] raw;
   logic [1:0] filt;
   logic       kclk_f, kdata_f, kclk_prev_reg, strobe;

   assign raw = {kdata, kclk};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk (clk),
            .rst (rst),
            .din (raw[gi]),
            .dout(filt[gi])
         );
      end
   endgenerate

   assign kclk_f  = filt[0];
   assign kdata_f = filt[1];
   assign strobe  = kclk_prev_reg & ~kclk_f;

   ps2_state_t    state_reg;
   logic [2:0]    bit_cnt_reg;
   logic [7:0]    shift_reg;
   logic          par_reg;
   logic [TW-1:0] timer_reg;
   logic          err_parity_reg, err_frame_reg;
   logic          byte_ok_reg;
   logic [7:0]    byte_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kclk_prev_reg  <= 1'b1;
         state_reg      <= IDLE;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         par_reg        <= 1'b0;
         timer_reg      <= '0;
         err_parity_reg <= 1'b0;
         err_frame_reg  <= 1'b0;
         byte_ok_reg    <= 1'b0;
         byte_reg       <= '0;
      end else begin
         kclk_prev_reg  <= kclk_f;
         err_parity_reg <= 1'b0;
         err_frame_reg  <= 1'b0;
         byte_ok_reg    <= 1'b0;
         if (state_reg == IDLE || strobe) timer_reg <= '0;
         else                             timer_reg <= timer_reg + TW'(1);
         case (state_reg)
            IDLE: if (strobe && !kdata_f) begin
               state_reg   <= DATA;
               bit_cnt_reg <= '0;
            end
            DATA: if (strobe) begin
               shift_reg   <= {kdata_f, shift_reg[7:1]};
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
            end
            PARITY: if (strobe) begin
               par_reg   <= kdata_f;
               state_reg <= STOP;
            end
            STOP: if (strobe) begin
               state_reg <= IDLE;
               if (!kdata_f)                    err_frame_reg  <= 1'b1;
               else if (!(^{shift_reg, par_reg})) err_parity_reg <= 1'b1;
               else begin
                  byte_ok_reg <= 1'b1;
                  byte_reg    <= shift_reg;
               end
            end
            default: state_reg <= IDLE;
         endcase
         // A stalled device abandons the frame; the next start bit resynchronises.
         if (state_reg != IDLE && !strobe && timer_reg == TW'(TIMEOUT_CYC - 1)) begin
            state_reg     <= IDLE;
            err_frame_reg <= 1'b1;
         end
      end
   end

   logic          ext_pend_reg, brk_pend_reg, overflow_reg;
   logic [HW-1:0] hist_reg;
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          is_prefix, is_discard, push, pop, full, wr_en;
   fifo_entry_t   mem [FIFO_DEPTH];
   fifo_entry_t   wr_entry, head;

   assign is_prefix  = (byte_reg == CODE_EXT) || (byte_reg == CODE_BRK);
   assign is_discard = (byte_reg == CODE_NUL) || (byte_reg == CODE_ERR);
   assign push       = byte_ok_reg && !is_prefix && !is_discard;
   assign pop        = (count_reg != '0) && m_ready;
   assign full       = (count_reg == CW'(FIFO_DEPTH));
   assign wr_en      = push && (!full || pop);
   assign wr_entry   = '{code: byte_reg, brk: brk_pend_reg, ext: ext_pend_reg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_pend_reg <= 1'b0;
         brk_pend_reg <= 1'b0;
         hist_reg     <= '0;
         overflow_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         if (byte_ok_reg) begin
            if (byte_reg == CODE_EXT)      ext_pend_reg <= 1'b1;
            else if (byte_reg == CODE_BRK) brk_pend_reg <= 1'b1;
            else begin
               ext_pend_reg <= 1'b0;
               brk_pend_reg <= 1'b0;
            end
         end
         if (push) hist_reg <= HW'({hist_reg, byte_reg});
         overflow_reg <= push && full && !pop;
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + CW'(wr_en) - CW'(pop);
      end
   end

   // Storage needs no reset: the count gates every read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= wr_entry;
   end

   assign head       = mem[rd_ptr_reg];
   assign m_valid    = (count_reg != '0);
   assign m_code     = m_valid ? head.code : 8'h00;
   assign m_brk      = m_valid & head.brk;
   assign m_ext      = m_valid & head.ext;
   assign hist       = hist_reg;
   assign err_parity = err_parity_reg;
   assign err_frame  = err_frame_reg;
   assign overflow   = overflow_reg;
   assign fifo_count = count_reg;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomised and directed bench for ps2_frame_rx against a frame-level reference model.
module tb_ps2_frame_rx;
   localparam int FILTER_LEN  = 4;
   localparam int TIMEOUT_CYC = 400;
   localparam int FIFO_DEPTH  = 8;
   localparam int HIST_BYTES  = 4;
   localparam int HALF        = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        kclk = 1'b1;
   logic        kdata = 1'b1;
   logic        m_ready = 1'b1;
   logic        m_valid, m_brk, m_ext, err_parity, err_frame, overflow;
   logic [7:0]  m_code;
   logic [31:0] hist;
   logic [3:0]  fifo_count;

   ps2_frame_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .FIFO_DEPTH (FIFO_DEPTH),
      .HIST_BYTES (HIST_BYTES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .kclk      (kclk),
      .kdata     (kdata),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_code    (m_code),
      .m_brk     (m_brk),
      .m_ext     (m_ext),
      .hist      (hist),
      .err_parity(err_parity),
      .err_frame (err_frame),
      .overflow  (overflow),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int chk_cnt = 0;
   int err_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: frame-level behaviour, FIFO contents as a queue.
   logic [9:0]  exp_q[$];
   logic [31:0] m_hist = '0;
   bit          m_ext_p = 0, m_brk_p = 0;
   int          exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
   int          got_perr = 0, got_ferr = 0, got_ovf = 0;
   int          max_cnt = 0;
   bit          rand_ready = 0;
   logic [9:0]  pop_e;

   task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
      if (!stop_ok)                    exp_ferr++;
      else if (!par_ok)                exp_perr++;
      else if (b == 8'hE0)             m_ext_p = 1;
      else if (b == 8'hF0)             m_brk_p = 1;
      else if (b == 8'h00 || b == 8'hFF) begin
         m_ext_p = 0;
         m_brk_p = 0;
      end else begin
         m_hist = {m_hist[23:0], b};
         if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({b, m_brk_p, m_ext_p});
         else                           exp_ovf++;
         m_ext_p = 0;
         m_brk_p = 0;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_hist  = '0;
      m_ext_p = 0;
      m_brk_p = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (err_parity) got_perr++;
         if (err_frame)  got_ferr++;
         if (overflow)   got_ovf++;
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (m_valid && m_ready) begin
            check_val("pop_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               pop_e = exp_q.pop_front();
               $display("pop code=%02h brk=%0d ext=%0d", m_code, m_brk, m_ext);
               check_val("pop_entry", {22'd0, m_code, m_brk, m_ext}, {22'd0, pop_e});
            end
         end
      end
   end

   always @(posedge clk) if (rand_ready) m_ready = 1'($urandom_range(0, 1));

   task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bad);
      logic [10:0] bits;
      bits = {~stop_bad, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         kdata = bits[i];
         repeat (HALF) @(posedge clk);
         kclk = 1'b0;
         if (i == 10) model_frame(b, !par_flip, !stop_bad);
         repeat (HALF) @(posedge clk);
         kclk = 1'b1;
      end
      repeat (HALF) @(posedge clk);
      kdata = 1'b1;
      repeat (HALF) @(posedge clk);
      $display("frame %02h par_flip=%0d stop_bad=%0d hist=%08h cnt=%0d", b, par_flip, stop_bad, hist, fifo_count);
   endtask

   task automatic send_partial(input int nbits);
      for (int i = 0; i <= nbits; i++) begin
         kdata = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         repeat (HALF) @(posedge clk);
         kclk = 1'b0;
         repeat (HALF) @(posedge clk);
         kclk = 1'b1;
      end
      kdata = 1'b1;
   endtask

   task automatic check_state(input string tag, input bit drained);
      @(negedge clk);
      check_val({tag, "_perr"}, got_perr, exp_perr);
      check_val({tag, "_ferr"}, got_ferr, exp_ferr);
      check_val({tag, "_ovf"},  got_ovf,  exp_ovf);
      check_val({tag, "_hist"}, hist,     m_hist);
      if (drained) check_val({tag, "_qleft"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check_val({tag, "_valid"}, m_valid, 0);
      check_val({tag, "_count"}, fifo_count, 0);
      check_val({tag, "_code"}, {m_code, m_brk, m_ext}, 0);
      check_val({tag, "_hist"}, hist, 0);
      check_val({tag, "_pulses"}, {err_parity, err_frame, overflow}, 0);
   endtask

   initial begin
      repeat (5) @(posedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (10) @(posedge clk);

      send_frame(8'h1C, 0, 0);
      check_state("single_1c", 1);
      check_val("single_1c_hist_abs", hist, 32'h0000_001C);

      max_cnt = 0;
      send_frame(8'hE0, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h75, 0, 0);
      check_state("ext_brk_75", 1);
      check_val("ext_brk_maxcnt", 32'(max_cnt <= 1), 32'd1);

      send_frame(8'h1C, 1, 0);
      check_state("parity_err", 1);

      m_ready = 1'b0;
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
      check_state("fill", 0);
      check_val("fill_count", fifo_count, 8);
      check_val("fill_head_stable", {m_valid, m_code}, {1'b1, 8'h01});
      check_val("fill_hist_abs", hist, 32'h0607_0809);
      m_ready = 1'b1;
      for (int i = 0; i < 40 && fifo_count != 0; i++) @(posedge clk);
      check_state("drain", 1);
      check_val("drain_count", fifo_count, 0);

      send_partial(4);
      exp_ferr++;
      repeat (TIMEOUT_CYC + 200) @(posedge clk);
      check_state("timeout", 1);
      send_frame(8'h29, 0, 0);
      check_state("after_timeout", 1);

      kdata = 1'b0;
      repeat (HALF) @(posedge clk);
      kclk = 1'b0;
      repeat (FILTER_LEN - 2) @(posedge clk);
      kclk = 1'b1;
      repeat (TIMEOUT_CYC + 200) @(posedge clk);
      kdata = 1'b1;
      check_state("glitch", 1);
      send_frame(8'h4D, 0, 0);
      check_state("after_glitch", 1);

      send_frame(8'hF0, 0, 0);
      send_partial(3);
      #3 rst = 1'b1;
      model_reset();
      check_reset_outputs("midframe_rst");
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      repeat (10) @(posedge clk);
      send_frame(8'h33, 0, 0);
      check_state("after_rst", 1);

      rand_ready = 1;
      for (int n = 0; n < 30; n++) begin
         int   sel;
         logic [7:0] b;
         sel = int'($urandom_range(0, 9));
         case (sel)
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = 8'h00;
            3: b = 8'hFF;
            default: b = 8'($urandom_range(0, 255));
         endcase
         send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
         check_state("rand", 1);
      end
      rand_ready = 0;
      m_ready = 1'b1;
      repeat (10) @(posedge clk);
      check_state("final", 1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
